// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_arbiter
// Brief    : Round-robin arbiter sharing one SPI master between NREQ
//            requesters. Optional watchdog enabled by SPI_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TMO_CYC = 1023
) (
  input  logic               FSCLK,
  input  logic               ARESETN,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  req_ss,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               done_err,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW+1:0]      fifo_wdata,
  input  logic               sresp,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH      = 2'd1,
    WAIT_RESP = 2'd2,
    COMPLETE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_win;
  logic            w_any;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_own_oh;

  generate
    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1) begin : g_param_check
      $error("spi_txn_arbiter: NREQ must be 2..8 and TMO_CYC >= 1");
    end
  endgenerate

  // Scan from the farthest candidate to the nearest so the nearest set bit
  // after rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    w_win = '0;
    w_any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        w_win = PW'(idx);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    w_own_oh = '0;
    w_win_oh[w_win]   = 1'b1;
    w_own_oh[r_owner] = 1'b1;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_wdog;
`endif

  always_ff @(posedge FSCLK) begin
    if (!ARESETN) begin
      r_state    <= IDLE;
      r_rr_ptr   <= PW'(NREQ - 1);
      r_owner    <= '0;
      grant      <= '0;
      done       <= '0;
      done_err   <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      busy       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_wdog     <= '0;
`endif
    end else begin
      grant      <= '0;
      done       <= '0;
      done_err   <= 1'b0;
      fifo_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            grant      <= w_win_oh;
            fifo_wdata <= {req_ss[2*int'(w_win) +: 2], req_data[DW*int'(w_win) +: DW]};
            r_owner    <= w_win;
            r_state    <= PUSH;
            busy       <= 1'b1;
          end
        end
        PUSH: begin
          if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            r_state    <= WAIT_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            r_wdog     <= '0;
`endif
          end
        end
        WAIT_RESP: begin
          // done is issued on the transition edge so it is high while in COMPLETE
          if (sresp) begin
            done     <= w_own_oh;
            r_rr_ptr <= r_owner;
            r_state  <= COMPLETE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_wdog == TW'(TMO_CYC - 1)) begin
            done     <= w_own_oh;
            done_err <= 1'b1;
            r_rr_ptr <= r_owner;
            r_state  <= COMPLETE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        COMPLETE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
